// File: rtl/dino_runner_core.sv
// Three-lane obstacle runner: game FSM, LFSR obstacle spawner, lives/score and a multiplexed 7-seg scan.
// Optional macro DINO_SPEEDUP_EN shortens the tick period as the score climbs.
module dino_runner_core #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned TICK_PERIOD    = 500,
  parameter int unsigned OBSTACLE_COUNT = 20,
  parameter int unsigned LIVES          = 3,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_start,
  input  logic                  run_game,
  output logic [NUM_DIGITS-1:0] com,
  output logic                  seg_a,
  output logic                  seg_g,
  output logic                  seg_d,
  output logic [1:0]            state,
  output logic                  collision_detected,
  output logic                  game_cleared,
  output logic [7:0]            score,
  output logic [1:0]            lives_left
);

  localparam int unsigned TICK_W = $clog2(TICK_PERIOD + 1);
  localparam int unsigned SCAN_W = $clog2(NUM_DIGITS);

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_TOP  = 2'b01;
  localparam logic [1:0] LANE_MID  = 2'b10;
  localparam logic [1:0] LANE_BOT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_OVER  = 2'b10,
    S_CLEAR = 2'b11
  } state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   dino_q, dino_d;
  logic [NUM_DIGITS-1:0][1:0]   field_q, field_d;
  logic [7:0]                   spawn_q, spawn_d;
  logic [7:0]                   score_q, score_d;
  logic [7:0]                   lfsr_q, lfsr_d;
  logic [1:0]                   lives_q, lives_d;
  logic [TICK_W-1:0]            tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0]            period;
  logic [SCAN_W-1:0]            scan_q, scan_d;
  logic [NUM_DIGITS-1:0]        com_q, com_d;
  logic                         seg_a_q, seg_a_d;
  logic                         seg_g_q, seg_g_d;
  logic                         seg_d_q, seg_d_d;
  logic                         up_prev_q, down_prev_q, start_prev_q;
  logic                         up_pulse, down_pulse, start_pulse;
  logic [1:0]                   src;
  logic [1:0]                   spawn_val;

`ifdef DINO_SPEEDUP_EN
  logic [TICK_W-1:0] period_q, period_d;

  // Period shrinks by TICK_PERIOD/8 per 8 points, never below TICK_PERIOD/4.
  function automatic logic [TICK_W-1:0] eff_period(input logic [7:0] s);
    logic [31:0] dec;
    dec = 32'(s >> 3) * 32'(TICK_PERIOD >> 3);
    if (dec + 32'(TICK_PERIOD >> 2) >= 32'(TICK_PERIOD)) return TICK_W'(TICK_PERIOD >> 2);
    return TICK_W'(32'(TICK_PERIOD) - dec);
  endfunction

  assign period = period_q;
`else
  assign period = TICK_W'(TICK_PERIOD);
`endif

  assign com                = com_q;
  assign seg_a              = seg_a_q;
  assign seg_g              = seg_g_q;
  assign seg_d              = seg_d_q;
  assign state              = state_q;
  assign score              = score_q;
  assign lives_left         = lives_q;
  assign collision_detected = (state_q == S_OVER);
  assign game_cleared       = (state_q == S_CLEAR);

  always_comb begin
    up_pulse    = btn_up & ~up_prev_q;
    down_pulse  = btn_down & ~down_prev_q;
    start_pulse = btn_start & ~start_prev_q;

    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Display: one digit per clk, digit 0 shows the dino.
    scan_d  = (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
    src     = (scan_q == '0) ? dino_q : field_q[scan_q];
    com_d   = ~(NUM_DIGITS'(1) << scan_q);
    seg_a_d = (src == LANE_TOP);
    seg_g_d = (src == LANE_MID);
    seg_d_d = (src == LANE_BOT);

    if (spawn_q >= 8'(OBSTACLE_COUNT) || spawn_q[0]) spawn_val = LANE_NONE;
    else if (lfsr_q[1:0] == LANE_NONE)               spawn_val = LANE_MID;
    else                                             spawn_val = lfsr_q[1:0];

    state_d    = state_q;
    dino_d     = dino_q;
    field_d    = field_q;
    spawn_d    = spawn_q;
    score_d    = score_q;
    lives_d    = lives_q;
    tick_cnt_d = tick_cnt_q;
`ifdef DINO_SPEEDUP_EN
    period_d   = period_q;
`endif

    if (start_pulse) begin
      state_d    = S_RUN;
      dino_d     = LANE_MID;
      field_d    = '0;
      spawn_d    = '0;
      score_d    = '0;
      lives_d    = 2'(LIVES);
      tick_cnt_d = '0;
`ifdef DINO_SPEEDUP_EN
      period_d   = TICK_W'(TICK_PERIOD);
`endif
    end else if (state_q == S_RUN && run_game) begin
      if (up_pulse && dino_q != LANE_TOP)        dino_d = dino_q - 2'd1;
      else if (down_pulse && dino_q != LANE_BOT) dino_d = dino_q + 2'd1;

      if (tick_cnt_q == period - TICK_W'(1)) begin
        tick_cnt_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) field_d[i] = field_q[i+1];
        field_d[NUM_DIGITS-1] = spawn_val;
        if (spawn_q < 8'(OBSTACLE_COUNT)) spawn_d = spawn_q + 8'd1;

        // Obstacle about to reach the dino column is judged against the pre-move dino.
        if (field_q[1] != LANE_NONE) begin
          if (field_q[1] == dino_q)  lives_d = lives_q - 2'd1;
          else if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end
`ifdef DINO_SPEEDUP_EN
        period_d = eff_period(score_d);
`endif
        if (lives_d == '0)                                               state_d = S_OVER;
        else if (spawn_d == 8'(OBSTACLE_COUNT) && field_d == '0)         state_d = S_CLEAR;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dino_q       <= LANE_MID;
      field_q      <= '0;
      spawn_q      <= '0;
      score_q      <= '0;
      lives_q      <= 2'(LIVES);
      tick_cnt_q   <= '0;
      lfsr_q       <= LFSR_SEED;
      scan_q       <= '0;
      com_q        <= '1;
      seg_a_q      <= 1'b0;
      seg_g_q      <= 1'b0;
      seg_d_q      <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef DINO_SPEEDUP_EN
      period_q     <= TICK_W'(TICK_PERIOD);
`endif
    end else begin
      state_q      <= state_d;
      dino_q       <= dino_d;
      field_q      <= field_d;
      spawn_q      <= spawn_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      tick_cnt_q   <= tick_cnt_d;
      lfsr_q       <= lfsr_d;
      scan_q       <= scan_d;
      com_q        <= com_d;
      seg_a_q      <= seg_a_d;
      seg_g_q      <= seg_g_d;
      seg_d_q      <= seg_d_d;
      up_prev_q    <= btn_up;
      down_prev_q  <= btn_down;
      start_prev_q <= btn_start;
`ifdef DINO_SPEEDUP_EN
      period_q     <= period_d;
`endif
    end
  end

endmodule

// File: tb/tb_dino_runner_core.sv
// Bench for dino_runner_core: directed/table checks on a tiny game (u_a) and
// randomized play on a larger game (u_b) compared against a behavioural model.
module tb_dino_runner_core;

  localparam int B_TP    = 16;
  localparam int B_OC    = 40;
  localparam int B_LIVES = 3;
  localparam int B_SEED  = 'h3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: LIVES=1, TICK_PERIOD=4, OBSTACLE_COUNT=2
  logic a_rst_n = 1'b0, a_up = 1'b0, a_dn = 1'b0, a_st = 1'b0, a_run = 1'b0;
  logic [7:0] a_com, a_score;
  logic       a_seg_a, a_seg_g, a_seg_d, a_coll, a_clr;
  logic [1:0] a_state, a_lives;

  dino_runner_core #(.NUM_DIGITS(8), .TICK_PERIOD(4), .OBSTACLE_COUNT(2), .LIVES(1),
                     .LFSR_SEED(8'hA5)) u_a (
    .clk(clk), .rst_n(a_rst_n), .btn_up(a_up), .btn_down(a_dn), .btn_start(a_st),
    .run_game(a_run), .com(a_com), .seg_a(a_seg_a), .seg_g(a_seg_g), .seg_d(a_seg_d),
    .state(a_state), .collision_detected(a_coll), .game_cleared(a_clr),
    .score(a_score), .lives_left(a_lives));

  // ---------------- instance B: randomized play
  logic b_rst_n = 1'b0, b_up = 1'b0, b_dn = 1'b0, b_st = 1'b0, b_run = 1'b0;
  logic [7:0] b_com, b_score;
  logic       b_seg_a, b_seg_g, b_seg_d, b_coll, b_clr;
  logic [1:0] b_state, b_lives;

  dino_runner_core #(.NUM_DIGITS(8), .TICK_PERIOD(B_TP), .OBSTACLE_COUNT(B_OC),
                     .LIVES(B_LIVES), .LFSR_SEED(8'h3C)) u_b (
    .clk(clk), .rst_n(b_rst_n), .btn_up(b_up), .btn_down(b_dn), .btn_start(b_st),
    .run_game(b_run), .com(b_com), .seg_a(b_seg_a), .seg_g(b_seg_g), .seg_d(b_seg_d),
    .state(b_state), .collision_detected(b_coll), .game_cleared(b_clr),
    .score(b_score), .lives_left(b_lives));

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic int lane_of(input int l);
    if ((l & 3) == 0) return 2;
    return l & 3;
  endfunction

  function automatic int seg2code(input logic [2:0] s);
    case (s)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      3'b000:  return 0;
      default: return 7;
    endcase
  endfunction

  function automatic logic [2:0] seg_of(input int code);
    return {code == 1, code == 2, code == 3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // LFSR of instance A, tracked from its reset value
  int a_lfsr;
  always @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) a_lfsr <= 'hA5;
    else          a_lfsr <= lfsr_next(a_lfsr);

  task automatic wait_cyc(input int t);
    if (cyc > t) chk("schedule", 32'(cyc), 32'(t));
    while (cyc < t) @(negedge clk);
  endtask

  task automatic read_a_digit(input int k, output int code);
    logic [7:0] want;
    int n;
    want = ~(8'd1 << k);
    n = 0;
    @(negedge clk);
    while (a_com !== want && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (a_com !== want) chk("digit_timeout", 32'(a_com), 32'(want));
    code = seg2code({a_seg_a, a_seg_g, a_seg_d});
  endtask

  task automatic start_a(output int s);
    a_st = 1'b1;
    @(negedge clk);
    a_st = 1'b0;
    s = cyc;
  endtask

  // ---------------- behavioural model of instance B
  int m_state, m_dino, m_spawn, m_cnt, m_score, m_lives, m_scan, m_period, m_lfsr;
  int m_field [8];
  bit m_pu, m_pd, m_ps;
  logic [7:0] e_com;
  logic [2:0] e_seg;

  always @(posedge clk or negedge b_rst_n) begin : b_model
    int d0, arr, src;
    bit pu, pd, ps, empty;
    if (!b_rst_n) begin
      m_state = 0; m_dino = 2; m_spawn = 0; m_cnt = 0; m_score = 0; m_lives = B_LIVES;
      m_scan = 0; m_period = B_TP; m_lfsr = B_SEED;
      foreach (m_field[i]) m_field[i] = 0;
      m_pu = 0; m_pd = 0; m_ps = 0;
      e_com = 8'hFF; e_seg = 3'b000;
    end else begin
      pu = b_up && !m_pu; pd = b_dn && !m_pd; ps = b_st && !m_ps;
      m_pu = b_up; m_pd = b_dn; m_ps = b_st;
      src = (m_scan == 0) ? m_dino : m_field[m_scan];
      e_com = ~(8'd1 << m_scan);
      e_seg = seg_of(src);
      m_scan = (m_scan + 1) % 8;
      d0 = m_dino;
      if (ps) begin
        m_state = 1; m_dino = 2; m_spawn = 0; m_cnt = 0; m_score = 0; m_lives = B_LIVES;
        m_period = B_TP;
        foreach (m_field[i]) m_field[i] = 0;
      end else if (m_state == 1 && b_run) begin
        if (pu && m_dino != 1)      m_dino = m_dino - 1;
        else if (pd && m_dino != 3) m_dino = m_dino + 1;
        if (m_cnt == m_period - 1) begin
          m_cnt = 0;
          arr = m_field[1];
          for (int i = 0; i < 7; i++) m_field[i] = m_field[i+1];
          m_field[7] = (m_spawn >= B_OC || (m_spawn % 2) == 1) ? 0 : lane_of(m_lfsr);
          if (m_spawn < B_OC) m_spawn = m_spawn + 1;
          if (arr != 0) begin
            if (arr == d0)          m_lives = m_lives - 1;
            else if (m_score < 255) m_score = m_score + 1;
          end
`ifdef DINO_SPEEDUP_EN
          m_period = B_TP - (m_score / 8) * (B_TP / 8);
          if (m_period < B_TP / 4) m_period = B_TP / 4;
`endif
          empty = 1;
          foreach (m_field[i]) if (m_field[i] != 0) empty = 0;
          if (m_lives == 0)                     m_state = 2;
          else if (m_spawn == B_OC && empty)    m_state = 3;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  typedef struct {
    logic up;
    logic dn;
    int   hold;
    int   lane;
  } mv_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    mv_t mv_tab [10];
    int  s, lane, code;
    logic [24:0] b_act, b_exp;

    mv_tab[0] = '{1'b1, 1'b0, 5, 1};  // held up: one step MID->TOP
    mv_tab[1] = '{1'b1, 1'b0, 1, 1};  // clamp at TOP
    mv_tab[2] = '{1'b0, 1'b1, 1, 2};
    mv_tab[3] = '{1'b0, 1'b1, 1, 3};
    mv_tab[4] = '{1'b0, 1'b1, 3, 3};  // clamp at BOT
    mv_tab[5] = '{1'b1, 1'b0, 3, 2};  // held up from BOT: only one step
    mv_tab[6] = '{1'b1, 1'b1, 1, 1};  // both from MID: up wins
    mv_tab[7] = '{1'b0, 1'b1, 1, 2};
    mv_tab[8] = '{1'b0, 1'b1, 1, 3};
    mv_tab[9] = '{1'b1, 1'b1, 1, 2};  // both from BOT: up wins

    repeat (3) @(negedge clk);
    chk("rst_com", 32'(a_com), 32'h0FF);
    chk("rst_seg", 32'({a_seg_a, a_seg_g, a_seg_d}), 32'h0);
    chk("rst_state", 32'(a_state), 32'h0);
    chk("rst_lives", 32'(a_lives), 32'h1);
    chk("rst_score", 32'(a_score), 32'h0);
    chk("rst_flags", 32'({a_coll, a_clr}), 32'h0);
    chk("rst_b_lives", 32'(b_lives), 32'(B_LIVES));

    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);
    chk("scan_first_com", 32'(a_com), 32'h0FE);
    chk("idle_state", 32'(a_state), 32'h0);

    a_st = 1'b1;
    @(negedge clk);
    chk("start_run", 32'(a_state), 32'h1);
    repeat (3) @(negedge clk);
    a_st = 1'b0;

    // movement table: keys applied while running, digit read back while paused
    for (int i = 0; i < 10; i++) begin
      a_up = mv_tab[i].up;
      a_dn = mv_tab[i].dn;
      a_run = 1'b1;
      repeat (mv_tab[i].hold) @(negedge clk);
      a_up = 1'b0;
      a_dn = 1'b0;
      a_run = 1'b0;
      read_a_digit(0, code);
      chk($sformatf("move_%0d", i), 32'(code), 32'(mv_tab[i].lane));
    end

    // collision run with a 100-clk pause between tick 1 and tick 2
    a_run = 1'b1;
    start_a(s);
    chk("coll_restart_state", 32'(a_state), 32'h1);
    wait_cyc(s + 3);
    lane = lane_of(a_lfsr);
    wait_cyc(s + 5);
    a_run = 1'b0;
    a_up = 1'b1;
    @(negedge clk);
    a_up = 1'b0;
    a_dn = 1'b1;
    @(negedge clk);
    a_dn = 1'b0;
    read_a_digit(0, code);
    chk("pause_dino_held", 32'(code), 32'h2);
    read_a_digit(7, code);
    chk("spawn_lane", 32'(code), 32'(lane));
    wait_cyc(s + 105);
    a_run = 1'b1;
    if (lane == 1)      a_up = 1'b1;
    else if (lane == 3) a_dn = 1'b1;
    @(negedge clk);
    a_up = 1'b0;
    a_dn = 1'b0;
    wait_cyc(s + 131);
    chk("pre_hit_state", 32'(a_state), 32'h1);
    @(negedge clk);
    chk("hit_state", 32'(a_state), 32'h2);
    chk("hit_flags", 32'({a_coll, a_clr}), 32'h2);
    chk("hit_score", 32'(a_score), 32'h0);
    chk("hit_lives", 32'(a_lives), 32'h0);
    a_up = 1'b1;
    @(negedge clk);
    a_up = 1'b0;
    a_dn = 1'b1;
    @(negedge clk);
    a_dn = 1'b0;
    read_a_digit(0, code);
    chk("over_dino_frozen", 32'(code), 32'(lane));
    chk("over_state_held", 32'(a_state), 32'h2);

    // dodge run: obstacle passes, field empties on tick 9
    start_a(s);
    chk("over_restart_state", 32'(a_state), 32'h1);
    chk("over_restart_lives", 32'(a_lives), 32'h1);
    wait_cyc(s + 3);
    lane = lane_of(a_lfsr);
    if (lane == 2) a_up = 1'b1;
    @(negedge clk);
    a_up = 1'b0;
    wait_cyc(s + 31);
    chk("dodge_pre_score", 32'(a_score), 32'h0);
    @(negedge clk);
    chk("dodge_score", 32'(a_score), 32'h1);
    chk("dodge_state_t8", 32'(a_state), 32'h1);
    wait_cyc(s + 35);
    chk("dodge_state_t8b", 32'(a_state), 32'h1);
    @(negedge clk);
    chk("clear_state", 32'(a_state), 32'h3);
    chk("clear_flags", 32'({a_coll, a_clr}), 32'h1);
    repeat (12) @(negedge clk);
    chk("clear_held", 32'({a_state, a_score}), 32'h301);
    start_a(s);
    chk("clear_restart_state", 32'(a_state), 32'h1);
    chk("clear_restart_score", 32'(a_score), 32'h0);
    chk("clear_restart_flags", 32'({a_coll, a_clr}), 32'h0);
    a_run = 1'b0;

    // randomized play on instance B against the model
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      b_act = {b_state, b_score, b_lives, b_com, b_seg_a, b_seg_g, b_seg_d, b_coll, b_clr};
      b_exp = {2'(m_state), 8'(m_score), 2'(m_lives), e_com, e_seg,
               m_state == 2, m_state == 3};
      chk("rand_cycle", 32'(b_act), 32'(b_exp));
      b_up    = ($urandom_range(0, 5) == 0);
      b_dn    = ($urandom_range(0, 5) == 0);
      b_st    = ($urandom_range(0, 699) == 0) || (i == 5);
      b_run   = ($urandom_range(0, 19) != 0);
      b_rst_n = !(i >= 10000 && i < 10003);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
